ysyx_24100027_mdu: RTL and testbench
====================================

YSYX_24100027_MDU -- requirements
Module: ysyx_24100027_mdu

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  block accepts a request; high only in IDLE.
REQ-006 op  in  3  RV32M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-007 src1, src2  in  32 each  rs1, rs2 operands.
REQ-008 flush  in  1  abort the in-flight operation.
REQ-009 out_valid  out  1  result valid; held until out_ready.
REQ-010 out_ready  in  1  consumer takes the result.
REQ-011 result  out  32  RV32M result.
REQ-012 alu_a, alu_b  out  32 each  operands driven to the shared external ALU.
REQ-013 alu_ctr  out  4  ALU control: 0000 add, 1000 sub.
REQ-014 alu_out  in  32  combinational ALU result.
REQ-015 alu_zero  in  1  ALU zero flag for the adder result.

Function
REQ-016 SHALL accept a request on the edge where in_valid && in_ready, latching op, src1 and src2.
REQ-017 SHALL step through states IDLE -> NEG_A -> NEG_B -> ITER (32 cycles, counter 0..31) -> NEG_LO -> NEG_HI -> DONE -> IDLE, one state per cycle except ITER.
REQ-018 SHALL assert out_valid exactly 37 cycles after the accept edge, independent of operand values.
REQ-019 NEG_A/NEG_B SHALL replace the operand with its magnitude via ALU sub (a=0) when the operand is treated as signed and is negative; otherwise the operand passes unchanged. Signed: mulh both, mulhsu src1 only, div/rem both.
REQ-020 Multiply ITER: if multiplier lsb=1 then hi=alu_out (ALU add hi+multiplicand), else hi unchanged; carry = (alu_out < multiplicand), unsigned local compare, 0 when no add; then {carry,hi,lo} shifted right by 1, multiplier held in lo.
REQ-021 Divide ITER: alu_a={rem[30:0],quo[31]}, alu_b=divisor, ALU sub; ge = rem[31] | !(alu_a < divisor), unsigned; if ge then rem=alu_out and quo={quo[30:0],1}, else rem=alu_a and quo={quo[30:0],0}.
REQ-022 NEG_LO/NEG_HI multiply: if the product sign is negative, lo=0-lo (ALU sub), then hi=~hi+alu_zero-of-lo-negation (ALU add).
REQ-023 NEG_LO/NEG_HI divide: quotient negated when the operand signs differ; remainder negated when the dividend is negative; both via ALU sub from 0.
REQ-024 Result select: mul=lo; mulh/mulhsu/mulhu=hi; div/divu=quotient; rem/remu=remainder.
REQ-025 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder=src1; signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0. Both SHALL go IDLE->DONE with out_valid one cycle after accept.
REQ-026 DONE SHALL hold out_valid and result stable until out_ready, then return to IDLE in the next cycle.
REQ-027 No new request SHALL be accepted in the cycle out_valid && out_ready occurs.
REQ-028 flush SHALL force IDLE on the next edge from any state, with no out_valid; flush overrides an accept in the same cycle.
REQ-029 In IDLE and DONE, alu_ctr SHALL be 0000 and alu_a=alu_b=0.

Reset
REQ-030 rst SHALL force IDLE, in_ready=1, out_valid=0, result=0, counter=0, alu_ctr=0000, alu_a=alu_b=0, abandoning any in-flight operation.
REQ-031 rst SHALL take priority over flush and over an accept in the same cycle.

Structure
REQ-032 Package ysyx_24100027_mdu_pkg SHALL hold the op encodings, the state enum, and ALU_ADD=4'b0000 and ALU_SUB=4'b1000.
REQ-033 No sub-module SHALL be used: the ALU stays external and shared, and the unsigned comparator is local logic used by both ITER modes.

Verification
REQ-034 mul 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 37 cycles after accept.
REQ-035 mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulh same operands -> 0x00000000.
REQ-036 div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu 5 / 0 -> 0xFFFFFFFF one cycle after accept; div 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-037 out_ready held low 5 cycles in DONE -> result and out_valid stable, in_ready=0 throughout.
REQ-038 flush at cycle 10 of a div -> IDLE next cycle, no out_valid; next request completes correctly.
REQ-039 rst asserted mid-ITER -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ysyx_24100027_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// external ALU control codes, FSM state type and small decode helpers.
package ysyx_24100027_mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEG_A  = 3'd1,
        ST_NEG_B  = 3'd2,
        ST_ITER   = 3'd3,
        ST_NEG_LO = 3'd4,
        ST_NEG_HI = 3'd5,
        ST_DONE   = 3'd6
    } mdu_state_e;

    // rs1 is interpreted as signed for mulh, mulhsu, div and rem
    function automatic logic src1_is_signed(input logic [2:0] op);
        logic v;
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: v = 1'b1;
            default:                            v = 1'b0;
        endcase
        return v;
    endfunction

    // rs2 is interpreted as signed for mulh, div and rem
    function automatic logic src2_is_signed(input logic [2:0] op);
        logic v;
        case (op)
            OP_MULH, OP_DIV, OP_REM: v = 1'b1;
            default:                 v = 1'b0;
        endcase
        return v;
    endfunction

    // hi holds the upper product / remainder, lo the lower product / quotient
    function automatic logic [31:0] sel_result(input logic [2:0] op,
                                               input logic [31:0] hi,
                                               input logic [31:0] lo);
        logic [31:0] v;
        case (op)
            OP_MUL:                       v = lo;
            OP_MULH, OP_MULHSU, OP_MULHU: v = hi;
            OP_DIV, OP_DIVU:              v = lo;
            OP_REM, OP_REMU:              v = hi;
            default:                      v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ysyx_24100027_mdu.sv
// Iterative RV32M multiply/divide unit. Sign handling and the 32 shift/add
// or shift/subtract steps all run through a shared external ALU; a local
// unsigned comparator provides the multiply carry and the divide ge bit.
module ysyx_24100027_mdu
    import ysyx_24100027_mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctr,
    input  logic [31:0] alu_out,
    input  logic        alu_zero
);

    mdu_state_e  r_state;
    logic [2:0]  r_op;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [31:0] r_a;       // |rs1|: multiplicand, or dividend before ITER
    logic [31:0] r_b;       // |rs2|: divisor
    logic [31:0] r_hi;      // product high / remainder
    logic [31:0] r_lo;      // multiplier then product low / quotient
    logic [4:0]  r_cnt;
    logic        r_zero;    // low-word negation was zero: carry into high word
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_result;

    logic        w_is_div;
    logic        w_neg_a;
    logic        w_neg_b;
    logic        w_neg_lo;
    logic [31:0] w_div_a;
    logic [31:0] w_cmp_x;
    logic [31:0] w_cmp_y;
    logic        w_lt;
    logic [31:0] w_sum;
    logic        w_carry;
    logic        w_ge;
    logic [31:0] w_hi_fix;
    logic        w_accept;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic [31:0] w_spec_result;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    assign w_is_div = r_op[2];
    assign w_neg_a  = src1_is_signed(r_op) & r_src1[31];
    assign w_neg_b  = src2_is_signed(r_op) & r_src2[31];
    // product sign (mul ops) and quotient sign (div ops) share one rule
    assign w_neg_lo = w_neg_a ^ w_neg_b;

    // shared unsigned comparator: multiply carry-out or divide trial compare
    assign w_div_a = {r_hi[30:0], r_lo[31]};
    assign w_cmp_x = w_is_div ? w_div_a : alu_out;
    assign w_cmp_y = w_is_div ? r_b : r_a;
    assign w_lt    = (w_cmp_x < w_cmp_y);

    assign w_sum   = r_lo[0] ? alu_out : r_hi;
    assign w_carry = r_lo[0] & w_lt;
    assign w_ge    = r_hi[31] | ~w_lt;

    assign w_hi_fix = (w_is_div ? w_neg_a : w_neg_lo) ? alu_out : r_hi;

    // divide corner cases resolved without iterating
    assign w_accept   = in_valid & r_in_ready;
    assign w_div_zero = op[2] & (src2 == 32'd0);
    assign w_div_ovf  = op[2] & ~op[0] & (src1 == 32'h8000_0000) & (src2 == 32'hFFFF_FFFF);
    assign w_spec_result = w_div_zero ? (op[1] ? src1 : 32'hFFFF_FFFF)
                                      : (op[1] ? 32'd0 : 32'h8000_0000);

    // ALU operand and control selection for the current state
    always_comb begin
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_ctr = ALU_ADD;
        case (r_state)
            ST_NEG_A: begin
                if (w_neg_a) begin
                    alu_b   = r_src1;
                    alu_ctr = ALU_SUB;
                end else begin
                    alu_b   = 32'd0;
                    alu_ctr = ALU_ADD;
                end
            end
            ST_NEG_B: begin
                if (w_neg_b) begin
                    alu_b   = r_src2;
                    alu_ctr = ALU_SUB;
                end else begin
                    alu_b   = 32'd0;
                    alu_ctr = ALU_ADD;
                end
            end
            ST_ITER: begin
                if (w_is_div) begin
                    alu_a   = w_div_a;
                    alu_b   = r_b;
                    alu_ctr = ALU_SUB;
                end else if (r_lo[0]) begin
                    alu_a   = r_hi;
                    alu_b   = r_a;
                    alu_ctr = ALU_ADD;
                end else begin
                    alu_a   = 32'd0;
                    alu_ctr = ALU_ADD;
                end
            end
            ST_NEG_LO: begin
                if (w_neg_lo) begin
                    alu_b   = r_lo;
                    alu_ctr = ALU_SUB;
                end else begin
                    alu_b   = 32'd0;
                    alu_ctr = ALU_ADD;
                end
            end
            ST_NEG_HI: begin
                if (w_is_div && w_neg_a) begin
                    alu_b   = r_hi;
                    alu_ctr = ALU_SUB;
                end else if (!w_is_div && w_neg_lo) begin
                    alu_a   = ~r_hi;
                    alu_b   = {31'd0, r_zero};
                    alu_ctr = ALU_ADD;
                end else begin
                    alu_a   = 32'd0;
                    alu_ctr = ALU_ADD;
                end
            end
            default: begin
                alu_a   = 32'd0;
                alu_b   = 32'd0;
                alu_ctr = ALU_ADD;
            end
        endcase
    end

    // control FSM with datapath registers and registered handshake/result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= 3'd0;
            r_src1      <= 32'd0;
            r_src2      <= 32'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_cnt       <= 5'd0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 5'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op       <= op;
                        r_src1     <= src1;
                        r_src2     <= src2;
                        r_in_ready <= 1'b0;
                        if (w_div_zero || w_div_ovf) begin
                            r_result    <= w_spec_result;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_NEG_A;
                        end
                    end
                end
                ST_NEG_A: begin
                    r_a     <= w_neg_a ? alu_out : r_src1;
                    r_state <= ST_NEG_B;
                end
                ST_NEG_B: begin
                    r_b     <= w_neg_b ? alu_out : r_src2;
                    r_hi    <= 32'd0;
                    r_lo    <= w_is_div ? r_a : (w_neg_b ? alu_out : r_src2);
                    r_cnt   <= 5'd0;
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    if (w_is_div) begin
                        r_hi <= w_ge ? alu_out : w_div_a;
                        r_lo <= {r_lo[30:0], w_ge};
                    end else begin
                        r_hi <= {w_carry, w_sum[31:1]};
                        r_lo <= {w_sum[0], r_lo[31:1]};
                    end
                    if (r_cnt == 5'd31) begin
                        r_cnt   <= 5'd0;
                        r_state <= ST_NEG_LO;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_NEG_LO: begin
                    if (w_neg_lo) begin
                        r_lo   <= alu_out;
                        r_zero <= alu_zero;
                    end else begin
                        r_zero <= 1'b0;
                    end
                    r_state <= ST_NEG_HI;
                end
                ST_NEG_HI: begin
                    r_hi        <= w_hi_fix;
                    r_result    <= sel_result(r_op, w_hi_fix, r_lo);
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 5'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100027_mdu.sv
// Self-checking bench for the RV32M multiply/divide unit: a cycle-level
// behavioural model (latency counter + 64-bit arithmetic) is compared with
// the DUT every cycle, plus directed cases with literal expectations.
`timescale 1ns/1ps
module tb_ysyx_24100027_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_out;
    logic        alu_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // external shared ALU
    assign alu_out  = (alu_ctr == 4'b1000) ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_zero = (alu_out == 32'd0);

    ysyx_24100027_mdu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M semantics from 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ub, q;
        logic [63:0] p;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        ub = {32'd0, b};
        r  = 32'd0;
        case (o)
            3'b000: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'b100: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin q = sa / sb; r = q[31:0]; end
            end
            3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin q = sa % sb; r = q[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // behavioural model state
    bit          m_known = 1'b0;
    bit          m_idle  = 1'b1;
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_exp   = 32'd0;
    logic [31:0] m_result = 32'd0;

    // model advance on each rising edge using the driven inputs
    always @(posedge clk) begin
        if (rst) begin
            m_known  <= 1'b1;
            m_idle   <= 1'b1;
            m_valid  <= 1'b0;
            m_result <= 32'd0;
        end else if (!m_known) begin
            m_idle <= 1'b1;
        end else if (flush) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_exp  <= ref_result(op, src1, src2);
                if (is_special(op, src1, src2)) begin
                    m_valid  <= 1'b1;
                    m_result <= ref_result(op, src1, src2);
                    m_wait   <= 0;
                end else begin
                    m_wait <= 36;
                end
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_idle  <= 1'b1;
            end
        end else begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid  <= 1'b1;
                m_result <= m_exp;
            end
        end
    end

    // per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (m_known) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, m_idle});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid) check("result", result, m_result);
            if (m_idle || m_valid) begin
                check("alu_a_idle", alu_a, 32'd0);
                check("alu_b_idle", alu_b, 32'd0);
                check("alu_ctr_idle", {28'd0, alu_ctr}, 32'd0);
            end
        end
    end

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (!(m_known && m_idle) && n < 300) begin
            @(negedge clk);
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            n++;
        end
        if (!(m_known && m_idle)) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: got busy expected idle within 300 cycles");
        end
    endtask

    task automatic run_dir(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                           input int hold);
        int lat;
        wait_idle(1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = o; src1 = a; src2 = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_result"}, result, exp);
            check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        // handshake with a competing request that must be ignored
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, "_release_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_release_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 3'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        // directed cases with hand-computed expectations
        run_dir("mul_7_m3",   3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 37, 0);
        run_dir("mulhu_m1",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 37, 0);
        run_dir("mulh_m1",    3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 37, 0);
        run_dir("mulhsu_m1",  3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 37, 0);
        run_dir("mulh_2_min", 3'b001, 32'd2,          32'h8000_0000, 32'hFFFF_FFFF, 37, 0);
        run_dir("div_m7_2",   3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 37, 5);
        run_dir("rem_m7_2",   3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 37, 0);
        run_dir("divu_5_0",   3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 5);
        run_dir("remu_5_0",   3'b111, 32'd5,          32'd0,         32'd5,         1, 0);
        run_dir("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_dir("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);
        run_dir("divu_100_7", 3'b101, 32'd100,        32'd7,         32'd14,        37, 0);

        // flush at cycle 10 of a divide
        wait_idle(1'b0);
        in_valid = 1'b1; op = 3'b100; src1 = 32'd1000; src2 = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        // flush beats a same-cycle accept
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept", {31'd0, in_ready}, 32'd1);
        run_dir("after_flush", 3'b100, 32'd1000, 32'd3, 32'd333, 37, 0);

        // reset in the middle of ITER, together with a request
        wait_idle(1'b0);
        in_valid = 1'b1; op = 3'b000; src1 = 32'd12345; src2 = 32'd678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctr", {28'd0, alu_ctr}, 32'd0);
        repeat (40) @(negedge clk);

        // randomized traffic with random back-pressure and occasional flush
        for (int k = 0; k < 60; k++) begin
            wait_idle(1'b1);
            in_valid = 1'b1;
            op   = 3'($urandom_range(0, 7));
            src1 = pick_operand();
            src2 = pick_operand();
            flush = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            in_valid = 1'b0;
            flush = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 40)) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        end
        wait_idle(1'b1);
        out_ready = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
